// File: rtl/or16_rr_sched.sv
// or16_rr_sched: round-robin arbiter that time-shares one registered bitwise-OR unit
// among NREQ requesters, with valid/ready on every request port and on the result.
module or16_rr_sched #(
   parameter int WIDTH = 16,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  resp_valid,
   output logic [WIDTH-1:0]      resp_data,
   output logic [IDW-1:0]        resp_id,
   input  logic                  resp_ready,
   output logic                  busy
);
   typedef enum logic {S_IDLE, S_RESP} state_t;
   state_t state, state_n;
   logic [IDW-1:0] rr_ptr, win_id;
   logic [WIDTH-1:0] win_data;
   logic found, can_accept, grant;
   always_comb begin
      int j;
      found = 1'b0;
      win_id = '0;
      win_data = '0;
      j = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(rr_ptr) + k) % NREQ;
         if (!found && req_valid[j[IDW-1:0]]) begin
            found = 1'b1;
            win_id = j[IDW-1:0];
            win_data = req_a[j*WIDTH +: WIDTH] | req_b[j*WIDTH +: WIDTH];
         end
      end
      // A held result frees its slot in the same cycle it is consumed.
      can_accept = state == S_IDLE || resp_ready;
      grant = found && can_accept && !rst;
      req_ready = grant ? {{(NREQ-1){1'b0}}, 1'b1} << win_id : '0;
      state_n = grant ? S_RESP : (resp_ready ? S_IDLE : state);
      busy = state == S_RESP;
      resp_valid = busy;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         rr_ptr <= '0;
         resp_data <= '0;
         resp_id <= '0;
      end else begin
         state <= state_n;
         if (grant) begin
            resp_data <= win_data;
            resp_id <= win_id;
            rr_ptr <= win_id == IDW'(NREQ - 1) ? '0 : win_id + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_or16_rr_sched.sv
// tb_or16_rr_sched: randomized and directed checks of or16_rr_sched against a
// cycle-level round-robin model held in plain variables.
module tb_or16_rr_sched;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [15:0] a [4];
   logic [15:0] b [4];
   logic [63:0] req_a, req_b;
   logic [3:0]  req_ready;
   logic        resp_valid, resp_ready, busy;
   logic [15:0] resp_data;
   logic [1:0]  resp_id;
   int vectors = 0, errors = 0;
   int m_ptr, m_id;
   bit m_valid;
   logic [15:0] m_data;

   assign req_a = {a[3], a[2], a[1], a[0]};
   assign req_b = {b[3], b[2], b[1], b[0]};
   always #5 clk = ~clk;

   or16_rr_sched dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
      .resp_id(resp_id), .resp_ready(resp_ready), .busy(busy)
   );

   function automatic int m_winner();
      for (int k = 0; k < 4; k++)
         if (req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      return -1;
   endfunction

   function automatic logic [3:0] m_ready();
      int w = m_winner();
      return ((!m_valid || resp_ready) && w >= 0) ? 4'(1 << w) : 4'b0000;
   endfunction

   task automatic m_reset();
      m_ptr = 0; m_valid = 0; m_data = '0; m_id = 0;
   endtask

   // advance one clock edge and update the model; returns #1 after the edge
   task automatic tick();
      int w = m_winner();
      bit g = (!m_valid || resp_ready) && w >= 0;
      @(posedge clk);
      if (g) begin
         m_data = a[w] | b[w]; m_id = w; m_valid = 1; m_ptr = (w + 1) % 4;
      end else if (m_valid && resp_ready) m_valid = 0;
      #1;
   endtask

   task automatic drain();
      req_valid = 0; resp_ready = 1; tick(); #1;
   endtask

   task automatic test_reset();
      rst = 1; req_valid = 4'b1111; resp_ready = 1;
      for (int i = 0; i < 4; i++) begin a[i] = 16'h1111 * 16'(i); b[i] = 16'h0; end
      m_reset();
      @(posedge clk); #1;
      vectors++;
      if (resp_valid !== 0 || busy !== 0 || req_ready !== 0 || resp_data !== 0 || resp_id !== 0) begin
         errors++;
         $display("FAIL reset: valid=%b busy=%b ready=%b data=%h id=%0d, want all zero",
                  resp_valid, busy, req_ready, resp_data, resp_id);
      end
      rst = 0; req_valid = 0; #1;
   endtask

   task automatic test_single();
      req_valid = 4'b0001; a[0] = 16'h00F0; b[0] = 16'h0F0F; resp_ready = 1; #1;
      vectors++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
      tick();
      vectors++;
      if (resp_valid !== 1 || resp_data !== 16'h0FFF || resp_id !== 0) begin
         errors++;
         $display("FAIL single_resp: valid=%b data=%h id=%0d want 1 0fff 0", resp_valid, resp_data, resp_id);
      end
      req_valid = 4'b1111; #1;
      vectors++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ptr: ready=%b want 0010", req_ready); end
      drain(); drain();
   endtask

   task automatic test_all_valid();
      int start = m_ptr;
      req_valid = 4'b1111; resp_ready = 1;
      for (int n = 0; n < 9; n++) begin
         for (int i = 0; i < 4; i++) begin a[i] = 16'($urandom); b[i] = 16'($urandom); end
         tick();
         vectors++;
         if (resp_valid !== 1 || resp_id !== 2'((start + n) % 4) || resp_data !== m_data) begin
            errors++;
            $display("FAIL all_valid[%0d]: valid=%b id=%0d data=%h want 1 %0d %h",
                     n, resp_valid, resp_id, resp_data, (start + n) % 4, m_data);
         end
      end
      drain();
   endtask

   task automatic test_backpressure();
      logic [15:0] d; logic [1:0] id; logic [3:0] exp;
      req_valid = 4'b0111; resp_ready = 1; tick();
      resp_ready = 0; d = resp_data; id = resp_id;
      for (int n = 0; n < 5; n++) begin
         a[n % 3] = 16'($urandom); #1;
         vectors++;
         if (req_ready !== 0 || resp_valid !== 1 || busy !== 1 || resp_data !== d || resp_id !== id) begin
            errors++;
            $display("FAIL backpressure[%0d]: ready=%b valid=%b data=%h id=%0d want 0000 1 %h %0d",
                     n, req_ready, resp_valid, resp_data, resp_id, d, id);
         end
         tick();
      end
      resp_ready = 1; exp = 4'(1 << ((int'(id) + 1) % 3)); #1;
      vectors++;
      if (req_ready !== exp || req_ready !== m_ready()) begin
         errors++; $display("FAIL bp_release: ready=%b want %b", req_ready, exp);
      end
      tick();
      drain();
   endtask

   task automatic test_operand_stability();
      req_valid = 4'b0010; a[1] = 16'h8000; b[1] = 16'h0001; resp_ready = 1;
      tick();
      req_valid = 0; a[1] = 16'hFFFF; resp_ready = 0;
      tick(); tick();
      vectors++;
      if (resp_valid !== 1 || resp_data !== 16'h8001 || resp_id !== 1) begin
         errors++;
         $display("FAIL operand_stable: valid=%b data=%h id=%0d want 1 8001 1", resp_valid, resp_data, resp_id);
      end
      drain();
   endtask

   task automatic test_withdrawal();
      int p;
      req_valid = 4'b0001; resp_ready = 1; tick();
      p = m_ptr; resp_ready = 0;
      req_valid = 4'b0100; tick();
      req_valid = 0; tick();
      resp_ready = 1; tick();
      vectors++;
      if (resp_valid !== 0 || busy !== 0 || resp_id !== 0) begin
         errors++; $display("FAIL withdraw_resp: valid=%b busy=%b id=%0d want 0 0 0", resp_valid, busy, resp_id);
      end
      req_valid = 4'b1111; #1;
      vectors++;
      if (req_ready !== 4'(1 << p)) begin
         errors++; $display("FAIL withdraw_ptr: ready=%b want %b", req_ready, 4'(1 << p));
      end
      drain();
   endtask

   task automatic test_reset_mid();
      req_valid = 4'b0100; resp_ready = 0; tick();
      #2 rst = 1; #1;
      m_reset();
      vectors++;
      if (resp_valid !== 0 || busy !== 0 || req_ready !== 0 || resp_data !== 0) begin
         errors++;
         $display("FAIL reset_mid: valid=%b busy=%b ready=%b data=%h want 0 0 0000 0000",
                  resp_valid, busy, req_ready, resp_data);
      end
      #2 rst = 0; req_valid = 4'b1010; resp_ready = 1; #1;
      vectors++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL reset_mid_ready: got %b want 0010", req_ready); end
      tick();
      vectors++;
      if (resp_valid !== 1 || resp_id !== 1) begin
         errors++; $display("FAIL reset_mid_grant: valid=%b id=%0d want 1 1", resp_valid, resp_id);
      end
      drain();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         req_valid = 4'($urandom);
         resp_ready = $urandom_range(0, 3) != 0;
         for (int i = 0; i < 4; i++) begin a[i] = 16'($urandom); b[i] = 16'($urandom); end
         #1;
         vectors++;
         if (req_ready !== m_ready() || resp_valid !== m_valid || busy !== m_valid ||
             resp_data !== m_data || resp_id !== 2'(m_id)) begin
            errors++;
            $display("FAIL random[%0d]: ready=%b valid=%b data=%h id=%0d want %b %b %h %0d",
                     n, req_ready, resp_valid, resp_data, resp_id, m_ready(), m_valid, m_data, m_id);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_valid();
      test_backpressure();
      test_operand_stability();
      test_withdrawal();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
